// File: rtl/md5_core_arbiter.sv
// md5_core_arbiter
//   Shares a single pancham MD5 core between NREQ candidate generators.
//   Requests are arbitrated round-robin and issued to the core through
//   registered outputs. Each issue pushes {requester tag, message} into an
//   in-order FIFO. Each digest from the core pops the FIFO head, so the digest
//   is routed back to its requester together with the message that produced it.
//
// Parameters
//   NREQ  : number of requesters (2..8)
//   DEPTH : max messages in flight (power of 2, 2..16)
//
// Ports
//   clk, reset          : clock, asynchronous active-low reset (0 = reset)
//   req_valid/msg/width : per-requester message, held until req_grant[i]
//   req_grant           : one-hot one-cycle pulse, request accepted
//   core_msg_in*        : to pancham msg_in / msg_in_width / msg_in_valid
//   core_ready          : pancham ready
//   core_msg_output     : pancham digest
//   core_msg_out_valid  : pancham digest valid
//   rsp_valid/digest/msg: one-hot digest return with originating message
//   busy                : FIFO non-empty or arbiter cooling down
//   err_orphan          : sticky, a digest arrived with no outstanding tag
//
// Optional feature (macro MD5_ARB_MATCH_EN)
//   target_hash : digest to search for
//   rsp_match   : registered with rsp_valid, digest equals target_hash
//   found       : sticky, set by the first match
//   found_msg   : message of the first match, held until reset

module md5_core_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*128-1:0] req_msg,
    input  logic [NREQ*8-1:0]   req_width,
    output logic [NREQ-1:0]     req_grant,
    output logic [127:0]        core_msg_in,
    output logic [7:0]          core_msg_in_width,
    output logic                core_msg_in_valid,
    input  logic                core_ready,
    input  logic [127:0]        core_msg_output,
    input  logic                core_msg_out_valid,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [127:0]        rsp_digest,
    output logic [127:0]        rsp_msg,
    output logic                busy,
`ifdef MD5_ARB_MATCH_EN
    input  logic [127:0]        target_hash,
    output logic                rsp_match,
    output logic                found,
    output logic [127:0]        found_msg,
`endif
    output logic                err_orphan
);

    localparam int unsigned TW = $clog2(NREQ);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_COOL
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] rr;
    logic [TW-1:0] win_idx;
    logic          win_found;
    logic [TW-1:0] cand_idx;
    logic          issue;
    logic          pop;

    logic [127:0]  msg_arr [NREQ];
    logic [7:0]    wid_arr [NREQ];

    logic [TW-1:0] tag_mem [DEPTH];
    logic [127:0]  msg_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign msg_arr[g] = req_msg[g*128 +: 128];
        assign wid_arr[g] = req_width[g*8 +: 8];
    end

    // First valid requester at or after rr, wrapping mod NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand_idx = TW'((32'(rr) + i) % NREQ);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // FSM next-state and issue decision
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_found && core_ready && (count != FULL_CNT)) begin
                    issue      = 1'b1;
                    state_next = S_COOL;
                end
            end
            S_COOL: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign pop  = core_msg_out_valid && (count != '0);
    assign busy = (count != '0) || (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= win_idx;
            msg_mem[wr_ptr] <= msg_arr[win_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr                <= '0;
            req_grant         <= '0;
            core_msg_in       <= '0;
            core_msg_in_width <= '0;
            core_msg_in_valid <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            rsp_valid         <= '0;
            rsp_digest        <= '0;
            rsp_msg           <= '0;
            err_orphan        <= 1'b0;
        end else begin
            req_grant         <= '0;
            core_msg_in_valid <= 1'b0;
            rsp_valid         <= '0;

            if (issue) begin
                core_msg_in        <= msg_arr[win_idx];
                core_msg_in_width  <= wid_arr[win_idx];
                core_msg_in_valid  <= 1'b1;
                req_grant[win_idx] <= 1'b1;
                wr_ptr             <= wr_ptr + 1'b1;
                rr <= (win_idx == TW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end

            if (pop) begin
                rsp_valid[tag_mem[rd_ptr]] <= 1'b1;
                rsp_digest                 <= core_msg_output;
                rsp_msg                    <= msg_mem[rd_ptr];
                rd_ptr                     <= rd_ptr + 1'b1;
            end else if (core_msg_out_valid) begin
                err_orphan <= 1'b1;
            end

            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MD5_ARB_MATCH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_match <= 1'b0;
            found     <= 1'b0;
            found_msg <= '0;
        end else begin
            rsp_match <= pop && (core_msg_output == target_hash);
            if (pop && (core_msg_output == target_hash) && !found) begin
                found     <= 1'b1;
                found_msg <= msg_mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_md5_core_arbiter.sv
module tb_md5_core_arbiter;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     req_valid;
    logic [511:0]   req_msg;
    logic [31:0]    req_width;
    logic [3:0]     req_grant;
    logic [127:0]   core_msg_in;
    logic [7:0]     core_msg_in_width;
    logic           core_msg_in_valid;
    logic           core_ready;
    logic [127:0]   core_msg_output;
    logic           core_msg_out_valid;
    logic [3:0]     rsp_valid;
    logic [127:0]   rsp_digest;
    logic [127:0]   rsp_msg;
    logic           busy;
    logic           err_orphan;
`ifdef MD5_ARB_MATCH_EN
    logic [127:0]   target_hash;
    logic           rsp_match;
    logic           found;
    logic [127:0]   found_msg;
`endif

    md5_core_arbiter #(.NREQ(4), .DEPTH(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_msg            (req_msg),
        .req_width          (req_width),
        .req_grant          (req_grant),
        .core_msg_in        (core_msg_in),
        .core_msg_in_width  (core_msg_in_width),
        .core_msg_in_valid  (core_msg_in_valid),
        .core_ready         (core_ready),
        .core_msg_output    (core_msg_output),
        .core_msg_out_valid (core_msg_out_valid),
        .rsp_valid          (rsp_valid),
        .rsp_digest         (rsp_digest),
        .rsp_msg            (rsp_msg),
        .busy               (busy),
`ifdef MD5_ARB_MATCH_EN
        .target_hash        (target_hash),
        .rsp_match          (rsp_match),
        .found              (found),
        .found_msg          (found_msg),
`endif
        .err_orphan         (err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       ready;
        logic [3:0] grant;
    } vec_t;

    vec_t         vecs [12];
    logic [3:0]   exp_b [10];
    logic [127:0] tb_msg [4];
    logic [7:0]   tb_wid [4];
    int           tests = 0;
    int           fails = 0;
    int           w;

    localparam logic [127:0] DIG_BASE = 128'hABCD0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pack_msgs();
        for (int i = 0; i < 4; i++) begin
            req_msg[i*128 +: 128] = tb_msg[i];
            req_width[i*8 +: 8]   = tb_wid[i];
        end
    endtask

    function automatic int oh2i(input logic [3:0] g);
        int r = 0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = i;
        return r;
    endfunction

    task automatic check_zero_outs(input string tag);
        check({tag, " grant"}, 128'(req_grant), 128'(0));
        check({tag, " core_msg_in"}, core_msg_in, 128'(0));
        check({tag, " core_width"}, 128'(core_msg_in_width), 128'(0));
        check({tag, " core_valid"}, 128'(core_msg_in_valid), 128'(0));
        check({tag, " rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({tag, " rsp_digest"}, rsp_digest, 128'(0));
        check({tag, " rsp_msg"}, rsp_msg, 128'(0));
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " err_orphan"}, 128'(err_orphan), 128'(0));
    endtask

    task automatic do_reset(input string tag);
        req_valid          = '0;
        core_ready         = 1'b1;
        core_msg_out_valid = 1'b0;
        core_msg_output    = '0;
        #2;
        reset = 1'b0;
        #1;
        check_zero_outs(tag);
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        req_valid          = '0;
        core_ready         = 1'b1;
        core_msg_out_valid = 1'b0;
        core_msg_output    = '0;
`ifdef MD5_ARB_MATCH_EN
        target_hash        = 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2;
`endif
        for (int i = 0; i < 4; i++) begin
            tb_msg[i] = 128'h1000 + 128'(i);
            tb_wid[i] = 8'(8 * (i + 1));
        end
        tb_msg[0] = 128'h61;
        tb_wid[0] = 8'd8;
        pack_msgs();

        vecs[0]  = '{4'b0001, 1'b1, 4'b0001};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0000};
        vecs[7]  = '{4'b0001, 1'b1, 4'b0001};
        vecs[8]  = '{4'b1001, 1'b1, 4'b1000};
        vecs[9]  = '{4'b1010, 1'b1, 4'b0010};
        vecs[10] = '{4'b0000, 1'b1, 4'b0000};
        vecs[11] = '{4'b0011, 1'b1, 4'b0001};

        exp_b[0] = 4'b0001; exp_b[1] = 4'b0000;
        exp_b[2] = 4'b0010; exp_b[3] = 4'b0000;
        exp_b[4] = 4'b0100; exp_b[5] = 4'b0000;
        exp_b[6] = 4'b1000; exp_b[7] = 4'b0000;
        exp_b[8] = 4'b0000; exp_b[9] = 4'b0000;

        // ---- single requester, "a" ----
        do_reset("rst0");
        req_valid = 4'b0001;
        tick();
        check("A grant", 128'(req_grant), 128'(4'b0001));
        check("A core_valid", 128'(core_msg_in_valid), 128'(1));
        check("A core_msg", core_msg_in, 128'h61);
        check("A core_width", 128'(core_msg_in_width), 128'(8));
        req_valid = '0;
        tick();
        check("A cool valid", 128'(core_msg_in_valid), 128'(0));
        check("A cool grant", 128'(req_grant), 128'(0));
        check("A hold msg", core_msg_in, 128'h61);
        core_msg_out_valid = 1'b1;
        core_msg_output    = 128'h0cc175b9c0f1b6a831c399e269772661;
        tick();
        core_msg_out_valid = 1'b0;
        check("A rsp_valid", 128'(rsp_valid), 128'(4'b0001));
        check("A rsp_digest", rsp_digest, 128'h0cc175b9c0f1b6a831c399e269772661);
        check("A rsp_msg", rsp_msg, 128'h61);
        tick();
        check("A rsp pulse", 128'(rsp_valid), 128'(0));
        check("A busy", 128'(busy), 128'(0));
        check("A orphan", 128'(err_orphan), 128'(0));

        tb_msg[0] = 128'h1000;
        pack_msgs();

        // ---- table: round-robin with immediate results ----
        do_reset("rst1");
        for (int k = 0; k < 12; k++) begin
            req_valid  = vecs[k].valid;
            core_ready = vecs[k].ready;
            tick();
            check($sformatf("T%0d grant", k), 128'(req_grant), 128'(vecs[k].grant));
            check($sformatf("T%0d core_valid", k), 128'(core_msg_in_valid), 128'(|vecs[k].grant));
            w = oh2i(vecs[k].grant);
            if (vecs[k].grant != 4'b0000) begin
                check($sformatf("T%0d core_msg", k), core_msg_in, tb_msg[w]);
                check($sformatf("T%0d core_width", k), 128'(core_msg_in_width), 128'(tb_wid[w]));
                core_msg_out_valid = 1'b1;
                core_msg_output    = DIG_BASE + 128'(w);
            end
            req_valid = '0;
            tick();
            core_msg_out_valid = 1'b0;
            check($sformatf("T%0d cool grant", k), 128'(req_grant), 128'(0));
            check($sformatf("T%0d rsp_valid", k), 128'(rsp_valid), 128'(vecs[k].grant));
            if (vecs[k].grant != 4'b0000) begin
                check($sformatf("T%0d rsp_digest", k), rsp_digest, DIG_BASE + 128'(w));
                check($sformatf("T%0d rsp_msg", k), rsp_msg, tb_msg[w]);
            end
        end
        core_ready = 1'b1;

        // ---- FIFO full: 4 grants, then stall until a pop ----
        do_reset("rst2");
        req_valid = 4'b1111;
        for (int t = 0; t < 10; t++) begin
            tick();
            check($sformatf("B t%0d grant", t + 1), 128'(req_grant), 128'(exp_b[t]));
        end
        check("B busy full", 128'(busy), 128'(1));
        core_msg_out_valid = 1'b1;
        core_msg_output    = 128'hB0;
        tick();
        core_msg_out_valid = 1'b0;
        check("B pop rsp_valid", 128'(rsp_valid), 128'(4'b0001));
        check("B pop rsp_msg", rsp_msg, tb_msg[0]);
        check("B pop same-edge grant", 128'(req_grant), 128'(0));
        tick();
        check("B after pop grant", 128'(req_grant), 128'(4'b0001));
        req_valid = '0;

        // ---- push and pop on one edge at count=2 ----
        do_reset("rst3");
        req_valid = 4'b1111;
        tick(); check("C t1 grant", 128'(req_grant), 128'(4'b0001));
        tick();
        tick(); check("C t3 grant", 128'(req_grant), 128'(4'b0010));
        tick();
        core_msg_out_valid = 1'b1;
        core_msg_output    = 128'hC0;
        tick();
        check("C t5 grant", 128'(req_grant), 128'(4'b0100));
        check("C t5 rsp oldest", 128'(rsp_valid), 128'(4'b0001));
        check("C t5 rsp_msg", rsp_msg, tb_msg[0]);
        req_valid       = '0;
        core_msg_output = 128'hC1;
        tick();
        check("C t6 rsp", 128'(rsp_valid), 128'(4'b0010));
        check("C t6 rsp_msg", rsp_msg, tb_msg[1]);
        core_msg_output = 128'hC2;
        tick();
        check("C t7 rsp", 128'(rsp_valid), 128'(4'b0100));
        check("C t7 rsp_digest", rsp_digest, 128'hC2);
        check("C t7 busy", 128'(busy), 128'(0));
        check("C t7 orphan", 128'(err_orphan), 128'(0));
        tick();
        core_msg_out_valid = 1'b0;
        check("C orphan rsp", 128'(rsp_valid), 128'(0));
        check("C orphan set", 128'(err_orphan), 128'(1));
        tick();
        tick();
        check("C orphan sticky", 128'(err_orphan), 128'(1));

        // ---- reset with 3 outstanding ----
        do_reset("rst4");
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) tick();
        check("D outstanding busy", 128'(busy), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        check_zero_outs("D midflight");
        req_valid = '0;
        tick();
        reset = 1'b1;
        core_msg_out_valid = 1'b1;
        core_msg_output    = 128'hD0;
        tick();
        core_msg_out_valid = 1'b0;
        check("D late rsp", 128'(rsp_valid), 128'(0));
        check("D late orphan", 128'(err_orphan), 128'(1));

`ifdef MD5_ARB_MATCH_EN
        // ---- match capture ----
        do_reset("rst5");
        req_valid = 4'b0100;
        tick();
        check("M grant2", 128'(req_grant), 128'(4'b0100));
        req_valid = '0;
        tick();
        core_msg_out_valid = 1'b1;
        core_msg_output    = 128'h82cf9fa647dd1b3fbd9de71bbfb83fb2;
        tick();
        core_msg_out_valid = 1'b0;
        check("M rsp_valid", 128'(rsp_valid), 128'(4'b0100));
        check("M rsp_match", 128'(rsp_match), 128'(1));
        check("M found", 128'(found), 128'(1));
        check("M found_msg", found_msg, tb_msg[2]);
        tick();
        check("M match pulse", 128'(rsp_match), 128'(0));
        req_valid = 4'b0001;
        tick();
        check("M grant0", 128'(req_grant), 128'(4'b0001));
        req_valid = '0;
        tick();
        core_msg_out_valid = 1'b1;
        tick();
        core_msg_out_valid = 1'b0;
        check("M second match", 128'(rsp_match), 128'(1));
        check("M second rsp_msg", rsp_msg, tb_msg[0]);
        check("M found_msg kept", found_msg, tb_msg[2]);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md5_core_arbiter.md
Name: md5_core_arbiter

Overview:
- Shares one pancham MD5 core between NREQ candidate generators.
- Round-robin arbitration on request, registered issue to the core, in-order tag FIFO to route each digest back to its requester.
- Echoes the originating message with each digest so a requester can report the preimage on a match.
- Sits between the generator front-ends and the single pancham instance.

Parameters:
NREQ, 4, number of requesters (2..8)
DEPTH, 4, max outstanding messages in flight (power of 2, 2..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset (0 = reset)
req_valid  in  NREQ  request i has a message; held with req_msg/req_width stable until req_grant[i] seen
req_msg  in  NREQ*128  message i at bits [i*128 +: 128]
req_width  in  NREQ*8  message width i at bits [i*8 +: 8]
req_grant  out  NREQ  one-hot one-cycle pulse: request i accepted
core_msg_in  out  128  to pancham msg_in
core_msg_in_width  out  8  to pancham msg_in_width
core_msg_in_valid  out  1  to pancham msg_in_valid, one-cycle pulse
core_ready  in  1  pancham ready
core_msg_output  in  128  pancham msg_output
core_msg_out_valid  in  1  pancham msg_out_valid
rsp_valid  out  NREQ  one-hot one-cycle pulse: digest for requester i
rsp_digest  out  128  digest, valid with rsp_valid
rsp_msg  out  128  message that produced rsp_digest
busy  out  1  FIFO non-empty or FSM not in S_IDLE
err_orphan  out  1  sticky: digest arrived with FIFO empty

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM=S_IDLE, rr pointer=0, FIFO empty, err_orphan=0. Reset mid-flight discards in-flight tags. A pancham result arriving later is treated as an orphan.
- FSM states S_IDLE, S_COOL.
- S_IDLE issue condition: any req_valid & core_ready & FIFO count<DEPTH. Winner is the first set req_valid searching from the rr pointer upward, mod NREQ.
- At the issue edge, all registered:
  - core_msg_in <= req_msg[w]; core_msg_in_width <= req_width[w]; core_msg_in_valid <= 1.
  - req_grant[w] <= 1.
  - Push {w, req_msg[w]} to FIFO.
  - rr <= (w+1) mod NREQ.
  - FSM -> S_COOL.
- S_COOL, exactly 1 cycle:
  - core_msg_in_valid, req_grant return to 0.
  - No issue; core_ready ignored; requester drops or advances req_valid.
  - -> S_IDLE.
- Issue rate: at most one per 2 cycles. Request-to-grant latency is 1 cycle when uncontended.
- core_msg_in / core_msg_in_width hold their last value between issues.
- Response path, independent of FSM:
  - On core_msg_out_valid with FIFO non-empty: pop head {tag, msg}; next edge rsp_valid[tag] <= 1, rsp_digest <= core_msg_output, rsp_msg <= msg. Latency 1 cycle.
  - On core_msg_out_valid with FIFO empty: no rsp_valid; err_orphan <= 1 (cleared only by reset).
- Simultaneous push and pop: both performed, count unchanged. Pop on a full FIFO frees a slot usable from the next cycle, not the same one.
- FIFO full: no issue even if core_ready=1; requests wait, no grant.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Round-robin fairness: a continuously valid requester is granted within NREQ issues.

Optional Feature:
- Macro MD5_ARB_MATCH_EN.
- Defined:
  - Adds input target_hash (128) and output rsp_match (1).
  - rsp_match = (core_msg_output == target_hash), registered alongside rsp_valid, 0 otherwise.
  - Adds sticky output found (1), set on first rsp_match, cleared by reset.
  - Adds found_msg (128), capturing rsp_msg at first match, never overwritten until reset.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single requester 0, req_msg=128'h61 (width 8), core_ready=1, then model result 128'h0cc175b9c0f1b6a831c399e269772661 -> req_grant=4'b0001 one cycle after req; core_msg_in_valid one pulse; rsp_valid=4'b0001 with that digest and rsp_msg=128'h61.
- All 4 requesters valid continuously, core_ready=1, instant results -> grant order 0,1,2,3,0,1; one issue every 2 cycles; each rsp routed to the matching one-hot bit.
- Model withholds results, DEPTH=4 -> exactly 4 grants then none while full. Release one result -> next grant no earlier than the cycle after the pop.
- Result and new issue on the same edge with count=2 -> count stays 2; rsp tag equals the oldest issued tag.
- core_msg_out_valid with FIFO empty -> no rsp_valid, err_orphan=1 and stays 1. Drive reset=0 mid-flight with 3 outstanding -> all outputs 0 immediately, busy=0.
- MD5_ARB_MATCH_EN, target_hash=128'h82cf9fa647dd1b3fbd9de71bbfb83fb2, matching result on requester 2 -> rsp_match=1, found=1, found_msg=rsp_msg. A later matching result leaves found_msg unchanged.
